// File: rtl/fft_power_avg.sv
// Per-bin |X|^2 averager for a pipelined FFT output stream.
// It accumulates 2^LGAVG frames in a RAM and emits one averaged value per bin.
//
// state  | meaning
// IDLE   | waiting for the first i_sync; samples are ignored
// RUN    | aligned to the frame; bin and frame counters advance on each i_ce
module fft_power_avg #(
    parameter int IW     = 22,
    parameter int LGSIZE = 11,
    parameter int LGAVG  = 4
) (
    input  logic                i_clk,
    input  logic                i_areset_n,
    input  logic                i_ce,
    input  logic [2*IW-1:0]     i_sample,
    input  logic                i_sync,
    output logic                o_valid,
    output logic [2*IW-1:0]     o_power,
    output logic [LGSIZE-1:0]   o_bin,
    output logic                o_first
);

    localparam int PW = 2 * IW;
    localparam int AW = PW + LGAVG;
    localparam int FW = (LGAVG > 0) ? LGAVG : 1;
    localparam logic [LGSIZE-1:0] LAST_BIN   = '1;
    localparam logic [FW-1:0]     LAST_FRAME = FW'((1 << LGAVG) - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t state;
    logic [LGSIZE-1:0] bin_cnt;
    logic [FW-1:0]     frame_cnt;

    logic signed [IW-1:0] in_re;
    logic signed [IW-1:0] in_im;
    logic                 start;
    logic                 accept;
    logic                 resync;
    logic [LGSIZE-1:0]    cur_bin;
    logic [FW-1:0]        cur_frame;

    // stage A: squares
    logic                 a_vld;
    logic                 a_first;
    logic                 a_last;
    logic [LGSIZE-1:0]    a_bin;
    logic signed [PW-1:0] a_sq_re;
    logic signed [PW-1:0] a_sq_im;

    // stage B: power, RAM read in flight
    logic                 b_vld;
    logic                 b_first;
    logic                 b_last;
    logic [LGSIZE-1:0]    b_bin;
    logic [PW-1:0]        b_p;

    // stage C: accumulated sum for the output register
    logic                 c_vld;
    logic                 c_last;
    logic [LGSIZE-1:0]    c_bin;
    logic [AW-1:0]        c_acc;

    logic [AW-1:0]        rd_data;
    logic [AW-1:0]        acc_next;
    logic                 emit;

    logic [AW-1:0] acc_mem [2**LGSIZE];

    assign in_re = i_sample[2*IW-1:IW];
    assign in_im = i_sample[IW-1:0];

    always_comb begin
        start     = 1'b0;
        accept    = 1'b0;
        resync    = 1'b0;
        cur_bin   = bin_cnt;
        cur_frame = frame_cnt;
        if (i_ce) begin
            resync = i_sync && (state == S_RUN) && (bin_cnt != '0);
            start  = i_sync && ((state == S_IDLE) || (bin_cnt != '0));
            accept = (state == S_RUN) || i_sync;
        end
        if (start) begin
            cur_bin   = '0;
            cur_frame = '0;
        end
    end

    assign acc_next = (b_first ? '0 : rd_data) + AW'(b_p);
    // A resync drops whatever is still in flight from the old alignment.
    assign emit     = i_ce && c_vld && c_last && !resync;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state     <= S_IDLE;
            bin_cnt   <= '0;
            frame_cnt <= '0;
            a_vld     <= 1'b0;
            a_first   <= 1'b0;
            a_last    <= 1'b0;
            a_bin     <= '0;
            a_sq_re   <= '0;
            a_sq_im   <= '0;
            b_vld     <= 1'b0;
            b_first   <= 1'b0;
            b_last    <= 1'b0;
            b_bin     <= '0;
            b_p       <= '0;
            c_vld     <= 1'b0;
            c_last    <= 1'b0;
            c_bin     <= '0;
            c_acc     <= '0;
            o_valid   <= 1'b0;
            o_first   <= 1'b0;
            o_power   <= '0;
            o_bin     <= '0;
        end else begin
            o_valid <= emit;
            o_first <= emit && (c_bin == '0);
            if (i_ce) begin
                if (accept) begin
                    state   <= S_RUN;
                    bin_cnt <= cur_bin + LGSIZE'(1);
                    if (cur_bin == LAST_BIN) begin
                        frame_cnt <= (cur_frame == LAST_FRAME) ? '0 : cur_frame + FW'(1);
                    end else begin
                        frame_cnt <= cur_frame;
                    end
                end

                a_vld   <= accept;
                a_first <= (cur_frame == '0);
                a_last  <= (cur_frame == LAST_FRAME);
                a_bin   <= cur_bin;
                a_sq_re <= PW'(in_re) * PW'(in_re);
                a_sq_im <= PW'(in_im) * PW'(in_im);

                b_vld   <= a_vld && !resync;
                b_first <= a_first;
                b_last  <= a_last;
                b_bin   <= a_bin;
                b_p     <= $unsigned(a_sq_re) + $unsigned(a_sq_im);

                c_vld   <= b_vld && !resync;
                c_last  <= b_last;
                c_bin   <= b_bin;
                c_acc   <= acc_next;

                if (emit) begin
                    o_power <= PW'(c_acc >> LGAVG);
                    o_bin   <= c_bin;
                end
            end
        end
    end

    // Write address trails the read address by one bin, so no bypass is needed.
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            rd_data <= acc_mem[a_bin];
            if (b_vld && !resync) begin
                acc_mem[b_bin] <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_fft_power_avg.sv
// Scoreboard bench for fft_power_avg: a frame-level model predicts each averaged
// strobe and its due enable count; a monitor compares whenever o_valid is seen.
module tb_fft_power_avg;

    localparam int IW     = 22;
    localparam int LGSIZE = 3;
    localparam int LGAVG  = 2;
    localparam int PW     = 2 * IW;
    localparam int NB     = 1 << LGSIZE;
    localparam int NF     = 1 << LGAVG;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              ce     = 1'b0;
    logic              sync   = 1'b0;
    logic [2*IW-1:0]   sample = '0;
    logic              o_valid;
    logic              o_first;
    logic [PW-1:0]     o_power;
    logic [LGSIZE-1:0] o_bin;

    fft_power_avg #(.IW(IW), .LGSIZE(LGSIZE), .LGAVG(LGAVG)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_ce       (ce),
        .i_sample   (sample),
        .i_sync     (sync),
        .o_valid    (o_valid),
        .o_power    (o_power),
        .o_bin      (o_bin),
        .o_first    (o_first)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint power;
        int     bin;
        bit     first;
        int     due;
    } exp_t;

    exp_t   exp_q[$];
    int     n_total    = 0;
    int     n_pass     = 0;
    int     drv_en     = 0;
    int     mon_en     = 0;
    int     n_seen     = 0;
    int     n_expected = 0;
    bit     m_run      = 1'b0;
    int     m_bin      = 0;
    int     m_frame    = 0;
    longint pw[NF][NB];

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic drop_pending();
        n_expected -= exp_q.size();
        exp_q.delete();
    endtask

    // Frame-level model: store each frame's power per bin, average on the last frame.
    task automatic model(input bit s, input logic signed [IW-1:0] re, input logic signed [IW-1:0] im);
        longint sum;
        exp_t   e;
        if (!m_run) begin
            if (!s) return;
            m_run   = 1'b1;
            m_bin   = 0;
            m_frame = 0;
        end else if (s && m_bin != 0) begin
            m_bin   = 0;
            m_frame = 0;
            drop_pending();
        end
        pw[m_frame][m_bin] = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        if (m_frame == NF - 1) begin
            sum = 0;
            for (int f = 0; f < NF; f++) sum += pw[f][m_bin];
            e.power = sum / NF;
            e.bin   = m_bin;
            e.first = (m_bin == 0);
            e.due   = drv_en + 3;
            exp_q.push_back(e);
            n_expected++;
        end
        m_bin++;
        if (m_bin == NB) begin
            m_bin   = 0;
            m_frame = (m_frame + 1) % NF;
        end
    endtask

    task automatic drive(input bit c, input bit s, input logic signed [IW-1:0] re, input logic signed [IW-1:0] im);
        @(negedge clk);
        ce     = c;
        sync   = s;
        sample = {re, im};
        if (c) begin
            drv_en++;
            model(s, re, im);
        end
    endtask

    function automatic logic signed [IW-1:0] rnd();
        return IW'($urandom);
    endfunction

    // mode 0: re=3 im=4, 1: ramp re=f+1, 2: most negative both, 3: random
    task automatic run(input int nfr, input int extra, input int mode, input int gap);
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
        int bin;
        int f;
        for (int i = 0; i < nfr * NB + extra; i++) begin
            bin = i % NB;
            f   = (i / NB) % NF;
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(99) < gap) drive(1'b0, 1'($urandom), rnd(), rnd());
            end
            case (mode)
                0: begin re = IW'(3); im = IW'(4); end
                1: begin re = IW'(f + 1); im = '0; end
                2: begin re = '0; re[IW-1] = 1'b1; im = re; end
                default: begin re = rnd(); im = rnd(); end
            endcase
            drive(1'b1, bin == 0, re, im);
        end
    endtask

    task automatic check_zero(input string tag);
        chk(o_valid == 1'b0, {tag, "_valid"}, longint'(o_valid), 0);
        chk(o_first == 1'b0, {tag, "_first"}, longint'(o_first), 0);
        chk(o_power == '0,   {tag, "_power"}, longint'(o_power), 0);
        chk(o_bin == '0,     {tag, "_bin"},   longint'(o_bin), 0);
    endtask

    initial begin
        bit   ce_edge;
        exp_t e;
        forever begin
            @(posedge clk);
            ce_edge = ce;
            if (ce_edge) mon_en++;
            #1;
            if (o_valid) begin
                n_seen++;
                chk(ce_edge == 1'b1, "valid_without_ce", longint'(ce_edge), 1);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_strobe_bin", longint'(o_bin), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(longint'(o_power) == e.power, "power", longint'(o_power), e.power);
                    chk(int'(o_bin) == e.bin, "bin", longint'(o_bin), e.bin);
                    chk(o_first == e.first, "first", longint'(o_first), longint'(e.first));
                    chk(mon_en == e.due, "latency_enable_count", mon_en, e.due);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due < mon_en) begin
                e = exp_q.pop_front();
                chk(1'b0, "missing_strobe_bin", -1, e.bin);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b0, '0, '0);
        repeat (3) drive(1'b1, 1'b0, IW'(3), IW'(4));

        run(8, 0, 0, 0);
        run(4, 0, 1, 0);
        run(4, 0, 2, 0);
        run(8, 0, 3, 30);

        run(2, 5, 3, 0);
        run(4, 0, 3, 0);
        run(3, 5, 0, 0);
        run(4, 0, 3, 0);

        run(3, 4, 3, 20);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        m_run = 1'b0;
        drop_pending();
        repeat (2) drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        repeat (5) drive(1'b1, 1'b0, rnd(), rnd());
        run(4, 0, 0, 10);
        run(0, 3, 0, 0);

        repeat (6) drive(1'b0, 1'b0, '0, '0);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        chk(n_seen == n_expected, "strobe_count", n_seen, n_expected);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
